// File: rtl/mul_prec_lanes.sv
// Multi-lane signed Q0.(WIDTH-1) multiplier with per-transaction output precision and a
// global-stall valid/ready pipeline. Define MUL_ROUND_EN to round modes 0 and 1 half-up.
module mul_prec_lanes #(
  parameter int WIDTH  = 16,
  parameter int LANES  = 4,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WIDTH-1:0]   in_a,
  input  logic [LANES*WIDTH-1:0]   in_b,
  input  logic [1:0]               in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*2*WIDTH-1:0] out_data,
  output logic [1:0]               out_mode,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     busy
);

  localparam int PW   = 2 * WIDTH;
  localparam int DW   = LANES * WIDTH;
  localparam int OW   = LANES * PW;
  localparam int PD   = (STAGES > 2) ? STAGES - 2 : 1;
  localparam int LAST = STAGES - 1;

  logic              advance;
  logic [STAGES-1:0] vld_q, vld_d;
  logic [1:0]        mode_q [STAGES];
  logic [1:0]        mode_d [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [TAG_W-1:0]  tag_d  [STAGES];
  logic [DW-1:0]     a_q, a_d, b_q, b_d;
  logic [OW-1:0]     prod_q [PD];
  logic [OW-1:0]     prod_d [PD];
  logic [OW-1:0]     prod_c, fmt_src, fmt_c, data_q, data_d;

  function automatic logic [PW-1:0] mul_lane(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic signed [PW-1:0] p;
    p = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    return p;
  endfunction

  // Select the Q1.x window of the Q1.(2W-2) product and sign-extend it back to 2W bits.
  function automatic logic [PW-1:0] fmt_lane(input logic [PW-1:0] p, input logic [1:0] m);
    logic [PW-1:0] r;
    case (m)
      2'd0:    r = {{(PW-8){p[PW-1]}}, p[PW-1 -: 8]};
      2'd1:    r = {{WIDTH{p[PW-1]}}, p[PW-1 -: WIDTH]};
      default: r = p;
    endcase
`ifdef MUL_ROUND_EN
    case (m)
      2'd0:    r = r + PW'(p[PW-9]);
      2'd1:    r = r + PW'(p[WIDTH-1]);
      default: ;
    endcase
`endif
    return r;
  endfunction

  always_comb begin
    prod_c = '0;
    for (int i = 0; i < LANES; i++)
      prod_c[i*PW +: PW] = mul_lane(a_q[i*WIDTH +: WIDTH], b_q[i*WIDTH +: WIDTH]);
  end

  assign fmt_src = (STAGES > 2) ? prod_q[PD-1] : prod_c;

  always_comb begin
    fmt_c = '0;
    for (int i = 0; i < LANES; i++)
      fmt_c[i*PW +: PW] = fmt_lane(fmt_src[i*PW +: PW], mode_q[LAST-1]);
  end

  // NOTE: every next-state signal gets a hold default before the conditional updates,
  // so no path through this block leaves a variable unassigned (no latches).
  always_comb begin
    advance = !vld_q[LAST] || out_ready;
    vld_d   = vld_q;
    mode_d  = mode_q;
    tag_d   = tag_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    data_d  = data_q;
    if (advance) begin
      vld_d = {vld_q[STAGES-2:0], in_valid};
      if (in_valid) begin
        a_d       = in_a;
        b_d       = in_b;
        mode_d[0] = (in_mode == 2'd3) ? 2'd2 : in_mode;
        tag_d[0]  = in_tag;
      end
      for (int s = 1; s < LAST; s++) begin
        mode_d[s] = mode_q[s-1];
        tag_d[s]  = tag_q[s-1];
      end
      prod_d[0] = prod_c;
      for (int s = 1; s < PD; s++) prod_d[s] = prod_q[s-1];
      // Output registers only load real items, so an idle block keeps its last result.
      if (vld_q[LAST-1]) begin
        data_d       = fmt_c;
        mode_d[LAST] = mode_q[LAST-1];
        tag_d[LAST]  = tag_q[LAST-1];
      end
    end
  end

  // NOTE: only valid bits and output-visible registers are reset; operand and product
  // stages are always qualified by their valid bit, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      data_q <= '0;
      mode_q <= '{default: '0};
      tag_q  <= '{default: '0};
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      mode_q <= mode_d;
      tag_q  <= tag_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    prod_q <= prod_d;
  end

  assign in_ready  = advance;
  assign out_valid = vld_q[LAST];
  assign out_data  = data_q;
  assign out_mode  = mode_q[LAST];
  assign out_tag   = tag_q[LAST];
  assign busy      = |vld_q;

endmodule
